// File: rtl/icevga_pkg.sv
// icevga_pkg: VRAM bus widths, host write entry layout and host read
// FSM state encoding shared by the VRAM arbiter files.
package icevga_pkg;

    localparam int VRAM_ADDR_W = 13;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUED,
        DATA
    } rd_state_t;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [VRAM_DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/host_wr_fifo.sv
// host_wr_fifo: small FIFO of host VRAM writes (address+data entries).
// A push into a full FIFO is still accepted when the same cycle pops.
module host_wr_fifo
    import icevga_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      nrst,
    input  logic      push,
    input  logic      pop,
    input  wr_entry_t din,
    output wr_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;
    wr_entry_t   mem [DEPTH];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Extra top bit tells a full FIFO from an empty one at equal indices
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM scheduler, display first, host fills gaps.
// Define VRAM_ARB_HOSTREAD_EN to compile in the host read path and FSM.
module vram_arbiter
    import icevga_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   dispReq,
    input  logic [VRAM_ADDR_W-1:0] dispAddr,
    output logic [VRAM_DATA_W-1:0] dispData,
    output logic                   dispValid,
    input  logic                   hostWr,
    input  logic [VRAM_ADDR_W-1:0] hostWrAddr,
    input  logic [VRAM_DATA_W-1:0] hostWrData,
    output logic                   hostWrFull,
    output logic                   hostOverflow,
    input  logic                   hostRdReq,
    input  logic [VRAM_ADDR_W-1:0] hostRdAddr,
    output logic [VRAM_DATA_W-1:0] hostRdData,
    output logic                   hostRdValid,
    output logic [VRAM_ADDR_W-1:0] memAddr,
    output logic [VRAM_DATA_W-1:0] memWrData,
    output logic                   memWr,
    input  logic [VRAM_DATA_W-1:0] memRdData
);

    wr_entry_t fifo_din;
    wr_entry_t fifo_head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      rd_grant;
    logic      wr_grant;
    logic      overflow_hit;
    logic      disp_p1;

    assign fifo_din = '{addr: hostWrAddr, data: hostWrData};

    host_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (hostWr),
        .pop   (wr_grant),
        .din   (fifo_din),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // rd_grant already excludes display cycles, so grants are one-hot
    assign wr_grant     = !dispReq && !rd_grant && !fifo_empty;
    assign overflow_hit = hostWr && fifo_full && !wr_grant;
    assign hostWrFull   = fifo_full;

`ifdef VRAM_ARB_HOSTREAD_EN
    rd_state_t state;
    rd_state_t state_next;
    logic      rd_pending;
    logic      rd_capture;

    // Writes drain before a read so the read sees every earlier write
    assign rd_pending = hostRdReq && !hostRdValid && fifo_empty;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (!dispReq && rd_pending) state_next = ISSUED;
            ISSUED:  state_next = DATA;
            DATA:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_grant   = 1'b0;
        rd_capture = 1'b0;
        unique case (state)
            IDLE:    rd_grant = !dispReq && rd_pending;
            ISSUED:  rd_grant = 1'b0;
            DATA:    rd_capture = 1'b1;
            default: rd_capture = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hostRdData  <= '0;
            hostRdValid <= 1'b0;
        end else begin
            hostRdValid <= rd_capture;
            if (rd_capture)
                hostRdData <= memRdData;
        end
    end
`else
    logic unused_rd;

    assign unused_rd   = ^{hostRdReq, hostRdAddr};
    assign rd_grant    = 1'b0;
    assign hostRdData  = '0;
    assign hostRdValid = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            memAddr      <= '0;
            memWrData    <= '0;
            memWr        <= 1'b0;
            disp_p1      <= 1'b0;
            dispValid    <= 1'b0;
            hostOverflow <= 1'b0;
        end else begin
            memWr     <= wr_grant;
            disp_p1   <= dispReq;
            dispValid <= disp_p1;
            if (overflow_hit)
                hostOverflow <= 1'b1;
            unique case (1'b1)
                dispReq:  memAddr <= dispAddr;
                rd_grant: memAddr <= hostRdAddr;
                wr_grant: begin
                    memAddr   <= fifo_head.addr;
                    memWrData <= fifo_head.data;
                end
                default: memAddr <= memAddr;
            endcase
        end
    end

    // VRAM returns the fetched byte in exactly the dispValid cycle
    assign dispData = dispValid ? memRdData : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a synchronous
// VRAM model; host read checks follow VRAM_ARB_HOSTREAD_EN.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        dispReq = 1'b0;
    logic [12:0] dispAddr = '0;
    logic [7:0]  dispData;
    logic        dispValid;
    logic        hostWr = 1'b0;
    logic [12:0] hostWrAddr = '0;
    logic [7:0]  hostWrData = '0;
    logic        hostWrFull;
    logic        hostOverflow;
    logic        hostRdReq = 1'b0;
    logic [12:0] hostRdAddr = '0;
    logic [7:0]  hostRdData;
    logic        hostRdValid;
    logic [12:0] memAddr;
    logic [7:0]  memWrData;
    logic        memWr;
    logic [7:0]  memRdData = '0;

    int tests = 0;
    int fails = 0;

    logic [7:0]  disp_q [$];
    logic [20:0] wr_q [$];
    logic [7:0]  rd_q [$];

    logic [7:0] vram [8192];
    bit         vld  [8192];

    vram_arbiter #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .dispReq      (dispReq),
        .dispAddr     (dispAddr),
        .dispData     (dispData),
        .dispValid    (dispValid),
        .hostWr       (hostWr),
        .hostWrAddr   (hostWrAddr),
        .hostWrData   (hostWrData),
        .hostWrFull   (hostWrFull),
        .hostOverflow (hostOverflow),
        .hostRdReq    (hostRdReq),
        .hostRdAddr   (hostRdAddr),
        .hostRdData   (hostRdData),
        .hostRdValid  (hostRdValid),
        .memAddr      (memAddr),
        .memWrData    (memWrData),
        .memWr        (memWr),
        .memRdData    (memRdData)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [12:0] a);
        return a[7:0] ^ 8'h79;
    endfunction

    // Synchronous VRAM: unwritten cells read back a fixed address pattern
    always @(posedge clk) begin
        if (memWr) begin
            vram[memAddr] <= memWrData;
            vld[memAddr]  <= 1'b1;
        end
        memRdData <= vld[memAddr] ? vram[memAddr] : pat(memAddr);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({memAddr, memWr, memWrData, dispData, dispValid} !== '0) begin
            fails++;
            $display("FAIL reset_mem_disp got %h want 0",
                     {memAddr, memWr, memWrData, dispData, dispValid});
        end
        tests++;
        if ({hostRdData, hostRdValid, hostWrFull, hostOverflow} !== '0) begin
            fails++;
            $display("FAIL reset_host got %h want 0",
                     {hostRdData, hostRdValid, hostWrFull, hostOverflow});
        end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_disp_fetch;
        logic [7:0] e;
        dispReq  = 1'b1;
        dispAddr = 13'h0123;
        disp_q.push_back(pat(13'h0123));
        tick();
        dispReq = 1'b0;
        tests++;
        if (memAddr !== 13'h0123 || memWr !== 1'b0) begin
            fails++;
            $display("FAIL disp_addr got %h/%b want 0123/0", memAddr, memWr);
        end
        tick();
        tests++;
        if (dispValid !== 1'b1) begin
            fails++;
            $display("FAIL disp_valid got %b want 1", dispValid);
        end
        e = disp_q.pop_front();
        tests++;
        if (dispData !== e || dispData !== 8'h5A) begin
            fails++;
            $display("FAIL disp_data got %h want %h", dispData, e);
        end
        tick();
        tests++;
        if (dispValid !== 1'b0) begin
            fails++;
            $display("FAIL disp_valid_end got %b want 0", dispValid);
        end
    endtask

    task automatic test_single_write;
        logic [20:0] e;
        hostWr     = 1'b1;
        hostWrAddr = 13'h1FFF;
        hostWrData = 8'hA5;
        wr_q.push_back({13'h1FFF, 8'hA5});
        tick();
        hostWr = 1'b0;
        tests++;
        if (memWr !== 1'b0) begin
            fails++;
            $display("FAIL wr_early got %b want 0", memWr);
        end
        tick();
        e = wr_q.pop_front();
        tests++;
        if (memWr !== 1'b1 || {memAddr, memWrData} !== e) begin
            fails++;
            $display("FAIL wr_single got %b %h want 1 %h",
                     memWr, {memAddr, memWrData}, e);
        end
        tick();
        tests++;
        if (memWr !== 1'b0 || hostWrFull !== 1'b0) begin
            fails++;
            $display("FAIL wr_after got %b/%b want 0/0", memWr, hostWrFull);
        end
    endtask

    task automatic test_disp_block;
        logic [20:0] e;
        logic [7:0]  d;
        logic        exp_wr;
        logic        exp_dv;
        for (int j = 0; j < 20; j++) begin
            dispReq    = (j < 10);
            dispAddr   = 13'h100 + 13'(j);
            hostWr     = (j == 2 || j == 4 || j == 6);
            hostWrAddr = 13'h200 + 13'(j);
            hostWrData = 8'h10 + 8'(j);
            if (dispReq) disp_q.push_back(pat(dispAddr));
            if (hostWr) wr_q.push_back({hostWrAddr, hostWrData});
            tick();
            exp_wr = (j + 1 >= 11 && j + 1 <= 13);
            exp_dv = (j >= 1 && j <= 10);
            tests++;
            if (memWr !== exp_wr) begin
                fails++;
                $display("FAIL blk_memwr c%0d got %b want %b", j + 1, memWr, exp_wr);
            end
            if (memWr === 1'b1 && wr_q.size() > 0) begin
                e = wr_q.pop_front();
                tests++;
                if ({memAddr, memWrData} !== e) begin
                    fails++;
                    $display("FAIL blk_wr got %h want %h", {memAddr, memWrData}, e);
                end
            end
            tests++;
            if (dispValid !== exp_dv) begin
                fails++;
                $display("FAIL blk_dv c%0d got %b want %b", j + 1, dispValid, exp_dv);
            end
            if (dispValid === 1'b1 && disp_q.size() > 0) begin
                d = disp_q.pop_front();
                tests++;
                if (dispData !== d) begin
                    fails++;
                    $display("FAIL blk_data got %h want %h", dispData, d);
                end
            end
        end
        hostWr = 1'b0;
        tests++;
        if (wr_q.size() != 0 || disp_q.size() != 0) begin
            fails++;
            $display("FAIL blk_queues got %0d/%0d want 0/0", wr_q.size(), disp_q.size());
        end
    endtask

    task automatic test_overflow;
        logic [20:0] e;
        logic [7:0]  d;
        int occ = 0;
        int nwr = 0;
        logic dropped = 1'b0;
        for (int j = 0; j < 8; j++) begin
            dispReq    = 1'b1;
            dispAddr   = 13'h0050;
            hostWr     = (j < 5);
            hostWrAddr = 13'h300 + 13'(j);
            hostWrData = 8'hC0 + 8'(j);
            disp_q.push_back(pat(dispAddr));
            if (hostWr) begin
                if (occ < 4) begin
                    wr_q.push_back({hostWrAddr, hostWrData});
                    occ++;
                end else begin
                    dropped = 1'b1;
                end
            end
            tick();
            tests++;
            if (hostWrFull !== (occ == 4)) begin
                fails++;
                $display("FAIL ovf_full c%0d got %b want %b", j, hostWrFull, occ == 4);
            end
            tests++;
            if (hostOverflow !== dropped) begin
                fails++;
                $display("FAIL ovf_flag c%0d got %b want %b", j, hostOverflow, dropped);
            end
            if (dispValid === 1'b1) d = disp_q.pop_front();
        end
        dispReq = 1'b0;
        hostWr  = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (memWr === 1'b1) begin
                nwr++;
                tests++;
                if (wr_q.size() == 0) begin
                    fails++;
                    $display("FAIL ovf_extra got %h want none", {memAddr, memWrData});
                end else begin
                    e = wr_q.pop_front();
                    if ({memAddr, memWrData} !== e) begin
                        fails++;
                        $display("FAIL ovf_wr got %h want %h", {memAddr, memWrData}, e);
                    end
                end
            end
            if (dispValid === 1'b1 && disp_q.size() > 0) begin
                d = disp_q.pop_front();
                tests++;
                if (dispData !== d) begin
                    fails++;
                    $display("FAIL ovf_disp got %h want %h", dispData, d);
                end
            end
        end
        tests++;
        if (nwr != 4 || hostOverflow !== 1'b1 || hostWrFull !== 1'b0) begin
            fails++;
            $display("FAIL ovf_end got %0d/%b/%b want 4/1/0", nwr, hostOverflow, hostWrFull);
        end
    endtask

`ifdef VRAM_ARB_HOSTREAD_EN
    task automatic test_host_read;
        logic [20:0] e;
        logic [7:0]  r;
        int wr_c = -1;
        int rd_c = -1;
        int pulses = 0;
        hostWr     = 1'b1;
        hostWrAddr = 13'h0040;
        hostWrData = 8'h77;
        wr_q.push_back({13'h0040, 8'h77});
        tick();
        hostWr     = 1'b0;
        hostRdReq  = 1'b1;
        hostRdAddr = 13'h0040;
        rd_q.push_back(8'h77);
        for (int c = 2; c < 16; c++) begin
            tick();
            if (memWr === 1'b1 && wr_q.size() > 0) begin
                wr_c = c;
                e = wr_q.pop_front();
                tests++;
                if ({memAddr, memWrData} !== e) begin
                    fails++;
                    $display("FAIL rd_wr got %h want %h", {memAddr, memWrData}, e);
                end
            end
            if (hostRdValid === 1'b1) begin
                pulses++;
                hostRdReq = 1'b0;
                if (rd_c < 0) begin
                    rd_c = c;
                    r = rd_q.pop_front();
                    tests++;
                    if (hostRdData !== r) begin
                        fails++;
                        $display("FAIL rd_data got %h want %h", hostRdData, r);
                    end
                end
            end
        end
        hostRdReq = 1'b0;
        tests++;
        if (wr_c != 2 || rd_c != wr_c + 3) begin
            fails++;
            $display("FAIL rd_timing got wr%0d rd%0d want wr2 rd5", wr_c, rd_c);
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL rd_pulses got %0d want 1", pulses);
        end
    endtask
`else
    task automatic test_host_read;
        hostRdReq  = 1'b1;
        hostRdAddr = 13'h0040;
        for (int c = 0; c < 6; c++) begin
            tick();
            tests++;
            if (hostRdValid !== 1'b0 || hostRdData !== 8'h00 || memWr !== 1'b0) begin
                fails++;
                $display("FAIL rd_off got %b/%h/%b want 0/00/0",
                         hostRdValid, hostRdData, memWr);
            end
        end
        hostRdReq = 1'b0;
    endtask
`endif

    task automatic test_reset_mid;
        logic [20:0] e;
        dispReq    = 1'b1;
        dispAddr   = 13'h00AA;
        hostWr     = 1'b1;
        hostWrAddr = 13'h0400;
        hostWrData = 8'h11;
        tick();
        hostWrAddr = 13'h0401;
        hostWrData = 8'h22;
        tick();
        hostWr = 1'b0;
        tick();
        #2;
        nrst = 1'b0;
        #1;
        tests++;
        if ({memAddr, memWr, memWrData, dispData, dispValid} !== '0 ||
            {hostRdData, hostRdValid, hostWrFull, hostOverflow} !== '0) begin
            fails++;
            $display("FAIL mid_reset got %h %h want 0",
                     {memAddr, memWr, memWrData, dispData, dispValid},
                     {hostRdData, hostRdValid, hostWrFull, hostOverflow});
        end
        disp_q.delete();
        wr_q.delete();
        @(posedge clk);
        #1;
        nrst    = 1'b1;
        dispReq = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            tests++;
            if (memWr !== 1'b0) begin
                fails++;
                $display("FAIL mid_stale_wr c%0d got %h want no write",
                         c, {memAddr, memWrData});
            end
        end
        hostWr     = 1'b1;
        hostWrAddr = 13'h0402;
        hostWrData = 8'h33;
        wr_q.push_back({13'h0402, 8'h33});
        tick();
        hostWr = 1'b0;
        tick();
        e = wr_q.pop_front();
        tests++;
        if (memWr !== 1'b1 || {memAddr, memWrData} !== e) begin
            fails++;
            $display("FAIL mid_new_wr got %b %h want 1 %h",
                     memWr, {memAddr, memWrData}, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_disp_fetch();
        test_single_write();
        test_disp_block();
        test_overflow();
        test_host_read();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
